rx_chan_pkt_fifo: RTL
=====================

// Module: rx_chan_pkt_fifo
// PURPOSE
//   Parametrised successor to the fixed 2-channel rx channel-FIFO stage.
//   - Captures I/Q pairs from NUM_CHAN receive channels on each rxstrobe.
//   - Interleaves each pair into a per-channel circular buffer.
//   - Round-robin arbiter hands whole packets (PKT_WORDS) to the downstream packet builder.
//   - Adds per-channel enable, atomic pair writes, per-channel sticky overrun and strobe-collision detect.
// PARAMETERS
//   NUM_CHAN   2    number of I/Q channels (1..4)
//   DEPTH      1024 words per channel buffer (power of 2, >= 2*PKT_WORDS)
//   PKT_WORDS  252  words per packet burst handed downstream (even, >= 2)
//   AW         10   log2(DEPTH)
// PORTS
//   rxclk        in   1             clock
//   reset        in   1             reset, synchronous, active-high
//   rxstrobe     in   1             sample strobe; one I/Q pair per enabled channel
//   chan_en      in   NUM_CHAN      per-channel capture enable
//   ch_data      in   32*NUM_CHAN   {Q,I} per channel; ch n at [32n+31:32n], I in low half
//   clear_status in   1             clears sticky status bits
//   sel_valid    out  1             a packet burst is being offered
//   sel_chan     out  2             channel of current burst
//   rd_req       in   1             pop one word of current burst
//   rd_data      out  16            head word of sel_chan buffer (valid while sel_valid)
//   rd_last      out  1             rd_data is final word of burst
//   overrun      out  NUM_CHAN      sticky: sample dropped, buffer full
//   strobe_err   out  1             sticky: rxstrobe while write sequencer busy
//   used_sel     out  AW+1          word count of sel_chan buffer
// BEHAVIOUR
//   Reset: all pointers/counts 0, sel_valid=0, sel_chan=0, rd_last=0, overrun=0, strobe_err=0.
//     rd_data=0; arbiter in IDLE; last-served channel = NUM_CHAN-1.
//   Capture: on rxstrobe with sequencer idle, latch ch_data and chan_en into staging registers.
//     Write sequencer then visits channels 0..NUM_CHAN-1 ascending.
//     For each enabled channel it spends 2 cycles, I first then Q.
//     Disabled channels cost 0 cycles. First write occurs the cycle after the strobe.
//   Atomic pair: space checked once per channel before the I write.
//     If free < 2, both words are dropped and overrun[n] is set.
//     A lone I is never written.
//   Strobe collision: rxstrobe while sequencer busy.
//     - Strobe ignored; staging unchanged; strobe_err set.
//     - Sequencer completes the current sample.
//   Buffers: one DEPTH x16 array per channel.
//     - wr/rd pointers wrap modulo DEPTH.
//     - count width AW+1; DEPTH words = full.
//     - Simultaneous write and pop on the same channel: count unchanged.
//   Arbiter FSM:
//     IDLE: scan from last-served+1 modulo NUM_CHAN.
//       The first channel with chan_en=1 and count >= PKT_WORDS wins.
//       Next cycle: BURST with sel_chan=winner, sel_valid=1.
//       No candidate -> stay IDLE.
//     BURST:
//       - rd_data = head word of sel_chan (first-word fall-through, same cycle).
//       - rd_req pops one word; word counter increments.
//       - rd_last=1 when counter == PKT_WORDS-1.
//       - Pop with rd_last -> IDLE, last-served=sel_chan, sel_valid=0 next cycle.
//       - rd_req is ignored outside BURST.
//   chan_en dropped mid-burst: the burst still completes; no new bursts are granted for that channel.
//   Disabled buffers keep their contents.
//   clear_status clears overrun and strobe_err.
//     If a set event occurs in the same cycle, set wins.
//   reset mid-burst: immediate return to reset state; buffered data is discarded.
// TESTING
//   1. NUM_CHAN=2, both enabled, 126 strobes every 8 clk -> ch0 burst of 252 words I0,Q0,I1,..; rd_last on word 252; then ch1 burst.
//   2. Fill ch0 to DEPTH-1 (no reads), strobe -> ch0 pair dropped, overrun[0]=1, ch1 written; clear_status -> 0.
//   3. Strobe at cycle 0 and 2 (NUM_CHAN=2, both enabled) -> second ignored, strobe_err=1, exactly 4 words written.
//   4. ch0, ch1 both >= PKT_WORDS, last-served=0 -> ch1 granted first, then ch0 (round-robin).
//   5. chan_en=2'b01 -> only ch0 grows, by 2 words/strobe; deassert chan_en[0] mid-burst -> burst finishes, no new grant.
//   6. Assert reset during BURST word 100 -> next cycle sel_valid=0, all used counts 0, overrun=0.

Source files
------------

// File: rtl/rx_chan_pkt_fifo.sv
// Multi-channel rx sample FIFO: captures I/Q pairs per strobe into per-channel circular
// buffers and hands whole packets downstream through a round-robin arbiter.
module rx_chan_pkt_fifo #(
    parameter int unsigned NUM_CHAN  = 2,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned PKT_WORDS = 252,
    parameter int unsigned AW        = 10
) (
    input  logic                   rxclk,
    input  logic                   reset,
    input  logic                   rxstrobe,
    input  logic [NUM_CHAN-1:0]    chan_en,
    input  logic [32*NUM_CHAN-1:0] ch_data,
    input  logic                   clear_status,
    output logic                   sel_valid,
    output logic [1:0]             sel_chan,
    input  logic                   rd_req,
    output logic [15:0]            rd_data,
    output logic                   rd_last,
    output logic [NUM_CHAN-1:0]    overrun,
    output logic                   strobe_err,
    output logic [AW:0]            used_sel
);

    localparam int unsigned CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int unsigned PW = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    // Staging registers and write sequencer
    logic [32*NUM_CHAN-1:0] stg_data_q, stg_data_d;
    logic [NUM_CHAN-1:0]    stg_en_q, stg_en_d;
    logic                   seq_busy_q, seq_busy_d;
    logic                   seq_ph_q, seq_ph_d;     // 0: I word next, 1: Q word next
    logic                   seq_drop_q, seq_drop_d; // current pair rejected for lack of space
    logic [CW-1:0]          seq_ch_q, seq_ch_d;
    logic                   wr_en;
    logic [15:0]            wr_word;

    // Buffers
    logic [15:0]   mem_q    [NUM_CHAN][DEPTH];
    logic [AW-1:0] wr_ptr_q [NUM_CHAN];
    logic [AW-1:0] rd_ptr_q [NUM_CHAN];
    logic [AW:0]   cnt_q    [NUM_CHAN];
    logic [NUM_CHAN-1:0] wr_hit, pop_hit;

    // Arbiter
    arb_state_e    state_q, state_d;
    logic [CW-1:0] sel_q, sel_d;
    logic [CW-1:0] last_q, last_d;
    logic [PW-1:0] wcnt_q, wcnt_d;
    logic          grant_found;
    logic [CW-1:0] grant_ch;
    logic          pop;

    // Status
    logic [NUM_CHAN-1:0] ovr_q, ovr_set;
    logic                serr_q, serr_set;

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
        return CW'((int'(base) + k) % int'(NUM_CHAN));
    endfunction

    // Write sequencer: capture on idle strobe, then I/Q per enabled channel in ascending order
    always_comb begin
        stg_data_d = stg_data_q;
        stg_en_d   = stg_en_q;
        seq_busy_d = seq_busy_q;
        seq_ph_d   = seq_ph_q;
        seq_drop_d = seq_drop_q;
        seq_ch_d   = seq_ch_q;
        wr_en      = 1'b0;
        ovr_set    = '0;
        serr_set   = 1'b0;
        if (!seq_busy_q) begin
            if (rxstrobe) begin
                stg_data_d = ch_data;
                stg_en_d   = chan_en;
                seq_ph_d   = 1'b0;
                seq_drop_d = 1'b0;
                for (int i = NUM_CHAN - 1; i >= 0; i--) begin
                    if (chan_en[i]) begin
                        seq_busy_d = 1'b1;
                        seq_ch_d   = CW'(i);
                    end
                end
            end
        end else begin
            serr_set = rxstrobe;
            if (!seq_ph_q) begin
                // Reserve room for the whole pair up front so a lone I is never stored
                if (cnt_q[seq_ch_q] > (AW + 1)'(DEPTH - 2)) begin
                    seq_drop_d       = 1'b1;
                    ovr_set[seq_ch_q] = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
                seq_ph_d = 1'b1;
            end else begin
                wr_en      = !seq_drop_q;
                seq_ph_d   = 1'b0;
                seq_drop_d = 1'b0;
                seq_busy_d = 1'b0;
                for (int i = NUM_CHAN - 1; i >= 0; i--) begin
                    if (stg_en_q[i] && (i > int'(seq_ch_q))) begin
                        seq_busy_d = 1'b1;
                        seq_ch_d   = CW'(i);
                    end
                end
            end
        end
    end

    assign wr_word = seq_ph_q ? stg_data_q[32*seq_ch_q+16 +: 16] : stg_data_q[32*seq_ch_q +: 16];

    // Sequencer and staging state
    always_ff @(posedge rxclk) begin
        if (reset) begin
            stg_data_q <= '0;
            stg_en_q   <= '0;
            seq_busy_q <= 1'b0;
            seq_ph_q   <= 1'b0;
            seq_drop_q <= 1'b0;
            seq_ch_q   <= '0;
        end else begin
            stg_data_q <= stg_data_d;
            stg_en_q   <= stg_en_d;
            seq_busy_q <= seq_busy_d;
            seq_ph_q   <= seq_ph_d;
            seq_drop_q <= seq_drop_d;
            seq_ch_q   <= seq_ch_d;
        end
    end

    // Per-channel write/pop decode
    always_comb begin
        wr_hit  = '0;
        pop_hit = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            wr_hit[c]  = wr_en && (seq_ch_q == CW'(c));
            pop_hit[c] = pop && (sel_q == CW'(c));
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge rxclk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (wr_hit[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                if (pop_hit[c]) rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                if (wr_hit[c] && !pop_hit[c]) begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end else if (!wr_hit[c] && pop_hit[c]) begin
                    cnt_q[c] <= cnt_q[c] - 1'b1;
                end
            end
        end
    end

    // Buffer storage
    always_ff @(posedge rxclk) begin
        if (wr_en && !reset) mem_q[seq_ch_q][wr_ptr_q[seq_ch_q]] <= wr_word;
    end

    // Arbiter next state: round-robin grant from last-served+1, whole-packet bursts
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        grant_found = 1'b0;
        grant_ch    = sel_q;
        // Descending k so the nearest eligible channel after last-served wins
        for (int k = NUM_CHAN; k >= 1; k--) begin
            if (chan_en[rr_idx(last_q, k)] &&
                (cnt_q[rr_idx(last_q, k)] >= (AW + 1)'(PKT_WORDS))) begin
                grant_found = 1'b1;
                grant_ch    = rr_idx(last_q, k);
            end
        end
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d = StBurst;
                    sel_d   = grant_ch;
                    wcnt_d  = '0;
                end
            end
            StBurst: begin
                if (rd_req) begin
                    if (wcnt_q == PW'(PKT_WORDS - 1)) begin
                        state_d = StIdle;
                        last_d  = sel_q;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= CW'(NUM_CHAN - 1);
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Sticky status; a set in the same cycle as clear_status wins
    always_ff @(posedge rxclk) begin
        if (reset) begin
            ovr_q  <= '0;
            serr_q <= 1'b0;
        end else begin
            ovr_q  <= (ovr_q & ~{NUM_CHAN{clear_status}}) | ovr_set;
            serr_q <= (serr_q & ~clear_status) | serr_set;
        end
    end

    assign sel_valid  = (state_q == StBurst);
    assign pop        = sel_valid && rd_req;
    assign rd_last    = sel_valid && (wcnt_q == PW'(PKT_WORDS - 1));
    assign rd_data    = sel_valid ? mem_q[sel_q][rd_ptr_q[sel_q]] : 16'd0;
    assign sel_chan   = 2'(sel_q);
    assign used_sel   = cnt_q[sel_q];
    assign overrun    = ovr_q;
    assign strobe_err = serr_q;

endmodule
